// File: rtl/render_pkg.sv
// Shared types and helpers for the Pong render scheduler and its pixel mux.
// Client indices, FSM state encoding and the enabled-client search live here.
package render_pkg;

  typedef enum logic [2:0] {INIT, BLACK, IDLE, MOVE, CLEAR, DRAW, HOLD} state_t;

  localparam int BALL = 0;
  localparam int LPAD = 1;
  localparam int RPAD = 2;

  localparam int MAX_CLIENTS = 8;
  typedef logic [MAX_CLIENTS-1:0] clientMask_t;
  typedef logic [3:0]             clientIdx_t;

  // Lowest enabled client at or above 'from'; returns MAX_CLIENTS when none is left.
  function automatic clientIdx_t nextEnabled(input clientMask_t en, input clientIdx_t from);
    clientIdx_t result;
    result = clientIdx_t'(MAX_CLIENTS);
    for (int i = MAX_CLIENTS - 1; i >= 0; i--) begin
      if (en[i] && (clientIdx_t'(i) >= from)) result = clientIdx_t'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/render_mux.sv
// Registered (N+1)-way pixel mux onto the single VGA plot port.
// Inputs 0..N-1 are render clients, input N is the background redraw.
module render_mux
  import render_pkg::*;
#(
  parameter int N   = 3,
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N:0]       i_grant,
  input  logic [N*X_W-1:0] i_cliX,
  input  logic [N*Y_W-1:0] i_cliY,
  input  logic [N*3-1:0]   i_cliCol,
  input  logic [X_W-1:0]   i_blkX,
  input  logic [Y_W-1:0]   i_blkY,
  input  logic [2:0]       i_blkCol,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic [2:0]       o_col,
  output logic             o_plot
);

  logic [X_W-1:0] w_x, r_x;
  logic [Y_W-1:0] w_y, r_y;
  logic [2:0]     w_col, r_col;
  logic           w_plot, r_plot;

  // Grant is one-hot; with no grant the coordinates are forced to zero.
  always_comb begin
    w_x    = '0;
    w_y    = '0;
    w_col  = '0;
    w_plot = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_grant[i]) begin
        w_x    = i_cliX[i*X_W +: X_W];
        w_y    = i_cliY[i*Y_W +: Y_W];
        w_col  = i_cliCol[i*3 +: 3];
        w_plot = 1'b1;
      end
    end
    if (i_grant[N]) begin
      w_x    = i_blkX;
      w_y    = i_blkY;
      w_col  = i_blkCol;
      w_plot = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_col  <= '0;
      r_plot <= 1'b0;
    end else begin
      r_x    <= w_x;
      r_y    <= w_y;
      r_col  <= w_col;
      r_plot <= w_plot;
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_col  = r_col;
  assign o_plot = r_plot;

endmodule

// File: rtl/render_scheduler.sv
// Frame sequencer and VGA-port arbiter for the Pong render path: physics strobe,
// per-client clear/draw walk, background redraw and post-score hold.
module render_scheduler
  import render_pkg::*;
#(
  parameter int N_CLIENTS      = 3,
  parameter int X_W            = 10,
  parameter int Y_W            = 9,
  parameter int HOLD_FRAMES    = 30,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     frameTick,
  input  logic                     score_event,
  input  logic [N_CLIENTS-1:0]     client_en,
  output logic [N_CLIENTS-1:0]     clear_go,
  output logic [N_CLIENTS-1:0]     draw_go,
  input  logic [N_CLIENTS-1:0]     done_clear,
  input  logic [N_CLIENTS-1:0]     done_draw,
  output logic                     black_go,
  input  logic                     done_black,
  output logic                     move_tick,
  input  logic [N_CLIENTS*X_W-1:0] cli_x,
  input  logic [N_CLIENTS*Y_W-1:0] cli_y,
  input  logic [N_CLIENTS*3-1:0]   cli_col,
  input  logic [X_W-1:0]           blk_x,
  input  logic [Y_W-1:0]           blk_y,
  input  logic [2:0]               blk_col,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [2:0]               vga_col,
  output logic                     vga_plot,
  output logic                     frame_overrun,
  output logic [N_CLIENTS:0]       timeout_err
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_t         r_state, w_nextState;
  logic [IW-1:0]  r_idx, w_nextIdx;
  logic [TW-1:0]  r_tmo;
  logic [HW-1:0]  r_hold;
  logic           r_afterScore, r_overrun;
  logic [N_CLIENTS:0] r_tmoErr;

  clientMask_t    w_en;
  clientIdx_t     w_first, w_after;
  logic           w_waitState, w_tmoHit, w_qual;
  logic [N_CLIENTS:0] w_grant;

  assign w_en        = clientMask_t'(client_en);
  assign w_first     = nextEnabled(w_en, clientIdx_t'(BALL));
  assign w_after     = nextEnabled(w_en, clientIdx_t'(r_idx) + clientIdx_t'(1));
  assign w_waitState = (r_state == BLACK) || (r_state == CLEAR) || (r_state == DRAW);
  assign w_tmoHit    = w_waitState && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  // The entry cycle of a phase has r_tmo == 0; a done seen then may be stale.
  assign w_qual      = (r_tmo != '0);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= INIT;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    case (r_state)
      INIT:  w_nextState = BLACK;
      BLACK: if ((done_black && w_qual) || w_tmoHit)
               w_nextState = r_afterScore ? HOLD : IDLE;
      IDLE:  if (frameTick) w_nextState = score_event ? BLACK : MOVE;
      MOVE:  if (w_first < clientIdx_t'(N_CLIENTS)) begin
               w_nextState = CLEAR;
               w_nextIdx   = w_first[IW-1:0];
             end else begin
               w_nextState = IDLE;
             end
      CLEAR: if ((done_clear[r_idx] && w_qual) || w_tmoHit) w_nextState = DRAW;
      DRAW:  if ((done_draw[r_idx] && w_qual) || w_tmoHit) begin
               if (w_after < clientIdx_t'(N_CLIENTS)) begin
                 w_nextState = CLEAR;
                 w_nextIdx   = w_after[IW-1:0];
               end else begin
                 w_nextState = IDLE;
               end
             end
      HOLD:  if (frameTick && (r_hold == HW'(HOLD_FRAMES - 1))) w_nextState = IDLE;
      default: w_nextState = INIT;
    endcase
  end

  always_comb begin
    clear_go  = '0;
    draw_go   = '0;
    black_go  = 1'b0;
    move_tick = 1'b0;
    case (r_state)
      BLACK:   black_go         = 1'b1;
      MOVE:    move_tick        = 1'b1;
      CLEAR:   clear_go[r_idx]  = 1'b1;
      DRAW:    draw_go[r_idx]   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_idx        <= '0;
      r_tmo        <= '0;
      r_hold       <= '0;
      r_afterScore <= 1'b0;
      r_overrun    <= 1'b0;
      r_tmoErr     <= '0;
    end else begin
      r_idx  <= w_nextIdx;
      r_tmo  <= ((w_nextState != r_state) || !w_waitState) ? '0 : r_tmo + TW'(1);
      r_hold <= (r_state != HOLD) ? '0 : (frameTick ? r_hold + HW'(1) : r_hold);
      if ((r_state == IDLE) && frameTick) r_afterScore <= score_event;
      if (frameTick && (r_state != IDLE) && (r_state != HOLD)) r_overrun <= 1'b1;
      if (w_tmoHit) begin
        if (r_state == BLACK) r_tmoErr[N_CLIENTS] <= 1'b1;
        else                  r_tmoErr[r_idx]     <= 1'b1;
      end
    end
  end

  assign frame_overrun = r_overrun;
  assign timeout_err   = r_tmoErr;
  assign w_grant       = {black_go, clear_go | draw_go};

  render_mux #(.N(N_CLIENTS), .X_W(X_W), .Y_W(Y_W)) u_mux (
    .clk      (clk),
    .resetn   (resetn),
    .i_grant  (w_grant),
    .i_cliX   (cli_x),
    .i_cliY   (cli_y),
    .i_cliCol (cli_col),
    .i_blkX   (blk_x),
    .i_blkY   (blk_y),
    .i_blkCol (blk_col),
    .o_x      (vga_x),
    .o_y      (vga_y),
    .o_col    (vga_col),
    .o_plot   (vga_plot)
  );

endmodule

// File: tb/tb_render_scheduler.sv
// Self-checking bench for render_scheduler: responder models for the clients,
// an event scoreboard for go/move sequencing and a per-cycle pixel-mux model.
module tb_render_scheduler;
  import render_pkg::*;

  localparam int N    = 3;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int HOLD = 30;
  localparam int TMO  = 64;

  localparam int K_NONE  = 0;
  localparam int K_MOVE  = 1;
  localparam int K_CLEAR = 2;
  localparam int K_DRAW  = 3;
  localparam int K_BLACK = 4;

  logic              clk = 1'b0;
  logic              resetn, frameTick, score_event;
  logic [N-1:0]      client_en, clear_go, draw_go, done_clear, done_draw;
  logic              black_go, done_black, move_tick;
  logic [N*XW-1:0]   cli_x;
  logic [N*YW-1:0]   cli_y;
  logic [N*3-1:0]    cli_col;
  logic [XW-1:0]     blk_x, vga_x;
  logic [YW-1:0]     blk_y, vga_y;
  logic [2:0]        blk_col, vga_col;
  logic              vga_plot, frame_overrun;
  logic [N:0]        timeout_err;

  always #5 clk = ~clk;

  render_scheduler #(
    .N_CLIENTS(N), .X_W(XW), .Y_W(YW), .HOLD_FRAMES(HOLD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .frameTick(frameTick), .score_event(score_event),
    .client_en(client_en), .clear_go(clear_go), .draw_go(draw_go),
    .done_clear(done_clear), .done_draw(done_draw), .black_go(black_go),
    .done_black(done_black), .move_tick(move_tick), .cli_x(cli_x), .cli_y(cli_y),
    .cli_col(cli_col), .blk_x(blk_x), .blk_y(blk_y), .blk_col(blk_col),
    .vga_x(vga_x), .vga_y(vga_y), .vga_col(vga_col), .vga_plot(vga_plot),
    .frame_overrun(frame_overrun), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  idx;
    logic [15:0] len;
  } event_t;

  typedef struct {
    logic [N-1:0] en;
    int           delay;
    int           expGrants;
    int           expLen;
  } vector_t;

  event_t expQ[$];
  vector_t vecs[6];

  int checks = 0;
  int errors = 0;
  int clrDelay[N], drwDelay[N], clrCnt[N], drwCnt[N];
  int blackDelay, blackCnt;
  int curKind, curIdx, curLen, grantsSeen;
  logic injectOnLpad;
  logic [N:0]      prevGrant;
  logic [N*XW-1:0] prevCliX;
  logic [N*YW-1:0] prevCliY;
  logic [N*3-1:0]  prevCliCol;
  logic [XW-1:0]   prevBlkX;
  logic [YW-1:0]   prevBlkY;
  logic [2:0]      prevBlkCol;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushEvent(input int kind, input int idx, input int len);
    event_t e;
    e.kind = 3'(kind);
    e.idx  = 4'(idx);
    e.len  = 16'(len);
    expQ.push_back(e);
  endtask

  task automatic finishEvent();
    event_t got, exp;
    got.kind = 3'(curKind);
    got.idx  = 4'(curIdx);
    got.len  = 16'(curLen);
    if (curKind == K_CLEAR || curKind == K_DRAW) grantsSeen++;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedEvent actual=%0h expected=none at %0t", got, $time);
    end else begin
      exp = expQ.pop_front();
      checkOutput("eventSeq", 64'(got), 64'(exp));
    end
  endtask

  // One clock: check the registered pixel, track go events, answer with done.
  task automatic stepCycle();
    int obsKind, obsIdx;
    logic expPlot;
    logic [XW-1:0] expX;
    logic [YW-1:0] expY;
    logic [2:0]    expCol;
    @(negedge clk);
    frameTick = 1'b0;

    expPlot = 1'b0; expX = '0; expY = '0; expCol = '0;
    if (resetn) begin
      for (int i = 0; i < N; i++) begin
        if (prevGrant[i]) begin
          expPlot = 1'b1;
          expX = prevCliX[i*XW +: XW];
          expY = prevCliY[i*YW +: YW];
          expCol = prevCliCol[i*3 +: 3];
        end
      end
      if (prevGrant[N]) begin
        expPlot = 1'b1; expX = prevBlkX; expY = prevBlkY; expCol = prevBlkCol;
      end
    end
    checkOutput("vgaPixel", 64'({vga_plot, vga_x, vga_y, vga_col}), 64'({expPlot, expX, expY, expCol}));
    checkOutput("oneHotGo", 64'($countones({clear_go, draw_go, black_go, move_tick}) <= 1), 64'd1);

    obsKind = K_NONE;
    obsIdx  = 0;
    if (black_go) obsKind = K_BLACK;
    else if (move_tick) obsKind = K_MOVE;
    else if (|clear_go) begin
      obsKind = K_CLEAR;
      for (int i = N - 1; i >= 0; i--) if (clear_go[i]) obsIdx = i;
    end else if (|draw_go) begin
      obsKind = K_DRAW;
      for (int i = N - 1; i >= 0; i--) if (draw_go[i]) obsIdx = i;
    end
    if (obsKind != curKind || obsIdx != curIdx) begin
      if (curKind != K_NONE) finishEvent();
      curKind = obsKind;
      curIdx  = obsIdx;
      curLen  = (obsKind == K_NONE) ? 0 : 1;
    end else if (curKind != K_NONE) begin
      curLen++;
    end

    for (int i = 0; i < N; i++) begin
      clrCnt[i] = clear_go[i] ? clrCnt[i] + 1 : 0;
      drwCnt[i] = draw_go[i] ? drwCnt[i] + 1 : 0;
      done_clear[i] = clear_go[i] && (clrDelay[i] != 0) && (clrCnt[i] >= clrDelay[i]);
      done_draw[i]  = draw_go[i] && (drwDelay[i] != 0) && (drwCnt[i] >= drwDelay[i]);
    end
    blackCnt   = black_go ? blackCnt + 1 : 0;
    done_black = black_go && (blackDelay != 0) && (blackCnt >= blackDelay);

    if (injectOnLpad && clear_go[LPAD]) begin
      frameTick    = 1'b1;
      injectOnLpad = 1'b0;
    end

    prevGrant = {black_go, clear_go | draw_go};
    cli_x   = (N*XW)'({$urandom(), $urandom()});
    cli_y   = (N*YW)'({$urandom(), $urandom()});
    cli_col = (N*3)'($urandom());
    blk_x   = XW'($urandom());
    blk_y   = YW'($urandom());
    blk_col = 3'($urandom());
    prevCliX = cli_x; prevCliY = cli_y; prevCliCol = cli_col;
    prevBlkX = blk_x; prevBlkY = blk_y; prevBlkCol = blk_col;
  endtask

  task automatic runUntilQuiet(input int budget, input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || curKind != K_NONE) && n < budget) begin
      stepCycle();
      n++;
    end
    checks++;
    if (expQ.size() != 0 || curKind != K_NONE) begin
      errors++;
      $display("[TB] FAIL %s pendingEvents=%0d required=0 (cycle budget expired)", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic setDelays(input int d);
    for (int i = 0; i < N; i++) begin
      clrDelay[i] = d;
      drwDelay[i] = d;
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    client_en = v.en;
    setDelays(v.delay);
    pushEvent(K_MOVE, 0, 1);
    for (int i = 0; i < N; i++) begin
      if (v.en[i]) begin
        pushEvent(K_CLEAR, i, v.expLen);
        pushEvent(K_DRAW, i, v.expLen);
      end
    end
    grantsSeen = 0;
    frameTick  = 1'b1;
    runUntilQuiet(300, "frame");
    checkOutput("grantCount", 64'(grantsSeen), 64'(v.expGrants));
    stepCycle();
  endtask

  initial begin
    vecs[0] = '{3'b111, 3, 6, 3};
    vecs[1] = '{3'b101, 3, 4, 3};
    vecs[2] = '{3'b010, 1, 2, 2};
    vecs[3] = '{3'b000, 3, 0, 0};
    vecs[4] = '{3'b110, 5, 4, 5};
    vecs[5] = '{3'b011, 2, 4, 2};

    resetn = 1'b0; frameTick = 1'b0; score_event = 1'b0; client_en = '1;
    done_clear = '0; done_draw = '0; done_black = 1'b0;
    cli_x = '0; cli_y = '0; cli_col = '0; blk_x = '0; blk_y = '0; blk_col = '0;
    prevGrant = '0; prevCliX = '0; prevCliY = '0; prevCliCol = '0;
    prevBlkX = '0; prevBlkY = '0; prevBlkCol = '0;
    curKind = K_NONE; curIdx = 0; curLen = 0; grantsSeen = 0; injectOnLpad = 1'b0;
    blackDelay = 5; blackCnt = 0;
    for (int i = 0; i < N; i++) begin clrCnt[i] = 0; drwCnt[i] = 0; end
    setDelays(3);

    repeat (3) stepCycle();
    checkOutput("resetOutputs",
      64'({clear_go, draw_go, black_go, move_tick, vga_plot, vga_x, vga_y, vga_col, frame_overrun, timeout_err}), 64'd0);

    pushEvent(K_BLACK, 0, 5);
    resetn = 1'b1;
    runUntilQuiet(50, "initBlack");
    repeat (3) stepCycle();

    for (int v = 0; v < 6; v++) applyStimulus(vecs[v]);
    checkOutput("noOverrunYet", 64'(frame_overrun), 64'd0);

    // Score at the IDLE decision: redraw, then 30 held frames with no physics.
    client_en = 3'b111;
    score_event = 1'b1;
    pushEvent(K_BLACK, 0, 5);
    frameTick = 1'b1;
    runUntilQuiet(50, "scoreBlack");
    score_event = 1'b0;
    for (int t = 0; t < HOLD; t++) begin
      frameTick = 1'b1;
      repeat (3) stepCycle();
    end
    checkOutput("holdNoOverrun", 64'(frame_overrun), 64'd0);
    applyStimulus(vecs[0]);

    // Right paddle never finishes drawing.
    client_en = 3'b111;
    setDelays(2);
    drwDelay[RPAD] = 0;
    pushEvent(K_MOVE, 0, 1);
    for (int i = 0; i < N; i++) begin
      pushEvent(K_CLEAR, i, 2);
      pushEvent(K_DRAW, i, (i == RPAD) ? TMO : 2);
    end
    frameTick = 1'b1;
    runUntilQuiet(400, "timeoutFrame");
    checkOutput("timeoutErr", 64'(timeout_err), 64'(4'b0100));
    stepCycle();

    // A stray frame tick during CLEAR(1) is dropped and flagged.
    setDelays(4);
    pushEvent(K_MOVE, 0, 1);
    for (int i = 0; i < N; i++) begin
      pushEvent(K_CLEAR, i, 4);
      pushEvent(K_DRAW, i, 4);
    end
    injectOnLpad = 1'b1;
    frameTick = 1'b1;
    runUntilQuiet(300, "overrunFrame");
    checkOutput("frameOverrun", 64'(frame_overrun), 64'd1);
    checkOutput("timeoutSticky", 64'(timeout_err), 64'(4'b0100));
    stepCycle();

    // Reset while the ball is drawing; everything drops and the redraw restarts.
    setDelays(3);
    pushEvent(K_MOVE, 0, 1);
    pushEvent(K_CLEAR, BALL, 3);
    frameTick = 1'b1;
    for (int n = 0; n < 50 && curKind != K_DRAW; n++) stepCycle();
    checkOutput("reachedDraw", 64'(curKind), 64'(K_DRAW));
    resetn = 1'b0;
    expQ.delete();
    curKind = K_NONE;
    curIdx = 0;
    stepCycle();
    checkOutput("midResetClear",
      64'({clear_go, draw_go, black_go, move_tick, frame_overrun, timeout_err}), 64'd0);
    stepCycle();
    pushEvent(K_BLACK, 0, 5);
    resetn = 1'b1;
    runUntilQuiet(50, "restartBlack");
    stepCycle();
    applyStimulus(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
Frame-level sequencer and VGA-port arbiter for the Pong render path. On each frame tick it pulses the physics update, then walks every enabled render client (ball, left paddle, right paddle) through its clear-old and draw-new phases one at a time. It also runs the full-screen background redraw after reset and after every score, holds play for a fixed number of frames, and muxes the granted client's pixel stream onto the single VGA plot port.

Parameters:
N_CLIENTS, 3, number of render clients; client 0 is the ball, 1 is the left paddle, 2 is the right paddle
X_W, 10, pixel X coordinate width
Y_W, 9, pixel Y coordinate width
HOLD_FRAMES, 30, frame ticks to freeze play after a score
TIMEOUT_CYCLES, 131072, maximum cycles a phase may wait for its done signal

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
frameTick  in  1  one-cycle frame strobe from the rate divider
score_event  in  1  level; lhs_scored OR rhs_scored from ball control
client_en  in  N_CLIENTS  per-client enable mask; a 0 skips that client
clear_go  out  N_CLIENTS  level; client i clears its old box while high
draw_go  out  N_CLIENTS  level; client i draws its new box while high
done_clear  in  N_CLIENTS  client i has finished clearing
done_draw  in  N_CLIENTS  client i has finished drawing
black_go  out  1  level; full-screen background redraw while high
done_black  in  1  background redraw finished
move_tick  out  1  one-cycle physics/paddle update strobe
cli_x  in  N_CLIENTS*X_W  flattened per-client render X
cli_y  in  N_CLIENTS*Y_W  flattened per-client render Y
cli_col  in  N_CLIENTS*3  flattened per-client colour
blk_x  in  X_W  background-redraw X
blk_y  in  Y_W  background-redraw Y
blk_col  in  3  background-redraw colour
vga_x  out  X_W  registered plot X
vga_y  out  Y_W  registered plot Y
vga_col  out  3  registered plot colour
vga_plot  out  1  registered plot enable
frame_overrun  out  1  sticky; a frameTick arrived while not in IDLE
timeout_err  out  N_CLIENTS+1  sticky; bit i = client i timed out, bit N = background redraw timed out

Behaviour:
- Reset: every output is 0, timeout/hold counters are 0, state is INIT. Sticky flags clear only on reset.
- States and transitions:
  - INIT -> BLACK unconditionally, one cycle after resetn rises.
  - BLACK: black_go = 1. Leave on a qualified done_black or on timeout.
    - After reset, BLACK -> IDLE.
    - After a score, BLACK -> HOLD.
  - IDLE: on frameTick:
    - if score_event is also high, go to BLACK; move_tick is not pulsed.
    - otherwise go to MOVE.
  - MOVE: move_tick = 1 for exactly one cycle, then go to CLEAR for the lowest-index enabled client.
  - CLEAR(i): clear_go[i] = 1 until a qualified done_clear[i] or timeout, then go to DRAW(i).
  - DRAW(i): draw_go[i] = 1 until a qualified done_draw[i] or timeout, then go to CLEAR for the next enabled client.
    - After the last enabled client, go to IDLE.
  - HOLD: count frameTicks; when the count reaches HOLD_FRAMES, go to IDLE. No move_tick is issued in HOLD.
- Client skipping:
  - Disabled clients are skipped with zero cycles spent on them.
  - client_en is sampled when each selection decision is made.
  - If all clients are disabled, MOVE -> IDLE.
- Done qualification: a done input counts only from the second cycle of its go onward, because clients may present a stale done on the entry cycle.
- Go deassertion: a go output falls on the cycle after a qualified done. At most one go bit (clear_go, draw_go or black_go) is high in any cycle.
- Timeout:
  - The counter clears on every state entry.
  - Reaching TIMEOUT_CYCLES-1 in BLACK, CLEAR or DRAW forces the exit, sets the matching timeout_err bit, and advances as if done had arrived.
- Overrun: a frameTick seen in any state other than IDLE or HOLD is dropped and sets frame_overrun.
- Score timing: score_event is acted on only at the IDLE frameTick decision. A score mid-frame finishes the current frame first.
- Pixel mux latency: the vga_* outputs are registered, 1 cycle after source selection.
  - vga_plot = 1 while any go is high.
  - Otherwise vga_plot = 0 and vga_x/vga_y/vga_col are held at 0.
- Reset mid-operation: all go outputs drop at the same clock edge, and the sequence restarts from INIT.

Decomposition:
- render_pkg holds:
  - the state enum: INIT, BLACK, IDLE, MOVE, CLEAR, DRAW, HOLD;
  - the client index constants BALL=0, LPAD=1, RPAD=2;
  - a next-enabled-client function (lowest set bit of client_en above the current index).
- Sub-module render_mux: the registered N+1-way pixel mux with plot-enable gating, selected by a one-hot grant.

Test Plan:
- Reset then release; done_black returns after 5 cycles -> black_go high for those cycles, then IDLE; vga_plot follows black_go one cycle later; move_tick stays 0.
- frameTick in IDLE with all clients enabled, each done returning after 3 cycles -> one move_tick, then the order clear0, draw0, clear1, draw1, clear2, draw2, then IDLE; no two go bits overlap.
- client_en=3'b101 -> client 1 is never granted; clear_go[1] and draw_go[1] stay 0; order is clear0, draw0, clear2, draw2.
- score_event high at the IDLE frameTick -> BLACK with no move_tick, then HOLD; exactly 30 more frameTicks before the next move_tick.
- done_draw[2] held low -> draw_go[2] falls after TIMEOUT_CYCLES cycles, timeout_err[2]=1, state returns to IDLE.
- frameTick injected during CLEAR(1) -> frame_overrun=1, the tick is ignored, and the current sequence completes unchanged.
